// File: rtl/idex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// idex_hazard_ctrl
//
// Hazard controller on the consumer side of the ID/EX register. It decodes the
// packed ID/EX bus, compares the producer's destination register against the
// source registers held in IF/ID, and steers the front end:
//   - load-use hazard    : freeze PC and IF/ID, bubble ID/EX for
//                          LOAD_STALL_CYCLES cycles
//   - EX control transfer: flush the wrong-path IF/ID instruction
// Saturating stall / flush event counters are kept for debug.
//
// Parameters
//   LOAD_STALL_CYCLES  bubble cycles per load-use hazard (1..3)
//   CNT_W              width of the event counters
//
// Ports
//   clk           clock
//   rst           asynchronous, active-high reset
//   idex_bus      122-bit ID/EX register output
//   ifid_rs       rs of the instruction in IF/ID
//   ifid_rt       rt of the instruction in IF/ID
//   ifid_uses_rt  IF/ID instruction reads rt
//   pc_write      PC load enable
//   ifid_write    IF/ID load enable
//   ifid_flush    clear IF/ID to NOP at the next edge
//   idex_nop      1 passes ID/EX control bits, 0 inserts a bubble
//   stall_cnt     cycles with pc_write=0 (saturating)
//   flush_cnt     flush events (saturating)
// -----------------------------------------------------------------------------
module idex_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [121:0]     idex_bus,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Cycles still to be spent in STALL after the RUN cycle that saw the hazard.
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // ID/EX bus decode
  // ---------------------------------------------------------------------------
  logic       mem_read;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;
  logic [4:0] dest;
  logic       ctl_xfer;
  logic       load_use;

  assign mem_read = idex_bus[118];
  assign pc_src   = idex_bus[117:116];
  assign reg_dst  = idex_bus[111];
  assign idex_rt  = idex_bus[14:10];
  assign idex_rd  = idex_bus[9:5];

  assign dest     = reg_dst ? idex_rd : idex_rt;
  assign ctl_xfer = (pc_src != 2'b00);

  // A load to $zero never produces a value a consumer could wait for.
  assign load_use = mem_read && (dest != 5'd0) &&
                    ((dest == ifid_rs) || (ifid_uses_rt && (dest == ifid_rt)));

  // Fields this block does not need: write-back/ALU controls, data, rs.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{idex_bus[121:119], idex_bus[115:112],
                             idex_bus[110:15],  idex_bus[4:0]};

  // ---------------------------------------------------------------------------
  // State and Mealy hazard logic
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] remain_q, remain_d;

  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_nop_c;

  // NOTE: every signal written here gets a default first so no path through
  // the case/if tree leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    idex_nop_c   = 1'b1;
    ifid_flush_c = 1'b0;
    state_d      = state_q;
    remain_d     = remain_q;

    case (state_q)
      ST_RUN: begin
        if (ctl_xfer) begin
          // Wrong-path IF/ID instruction: flush it, any hazard it had is moot.
          ifid_flush_c = 1'b1;
          idex_nop_c   = 1'b0;
        end else if (load_use) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_nop_c   = 1'b0;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d  = ST_STALL;
            remain_d = STALL_RELOAD;
          end
        end
      end

      ST_STALL: begin
        // ID/EX holds a bubble here; the bus carries no information.
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        idex_nop_c   = 1'b0;
        remain_d     = remain_q - 2'd1;
        if (remain_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d  = ST_RUN;
        remain_d = 2'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held.
  assign pc_write   = ~rst & pc_write_c;
  assign ifid_write = ~rst & ifid_write_c;
  assign idex_nop   = ~rst & idex_nop_c;
  assign ifid_flush = ~rst & ifid_flush_c;

  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ifid_flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      remain_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idex_hazard_ctrl
//
// Directed bench for idex_hazard_ctrl. Three instances share the stimulus:
//   dut_a : LOAD_STALL_CYCLES=1, CNT_W=16
//   dut_b : LOAD_STALL_CYCLES=3, CNT_W=16
//   dut_c : LOAD_STALL_CYCLES=1, CNT_W=4   (counter saturation)
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_idex_hazard_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [121:0] idex_bus;
  logic [4:0]   ifid_rs;
  logic [4:0]   ifid_rt;
  logic         ifid_uses_rt;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_nop;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_nop;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic        c_pc_write, c_ifid_write, c_ifid_flush, c_idex_nop;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .idex_bus(idex_bus), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .idex_nop(a_idex_nop), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  idex_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .idex_bus(idex_bus), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .idex_nop(b_idex_nop), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  idex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .idex_bus(idex_bus), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .pc_write(c_pc_write), .ifid_write(c_ifid_write), .ifid_flush(c_ifid_flush),
    .idex_nop(c_idex_nop), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build an ID/EX bus word; data fields carry filler so they are not all-zero.
  function automatic logic [121:0] mk_bus(input logic mr, input logic [1:0] pcs,
                                          input logic rdst, input logic [4:0] rt,
                                          input logic [4:0] rd);
    logic [121:0] b;
    b          = '0;
    b[121]     = mr;
    b[120]     = mr;
    b[118]     = mr;
    b[117:116] = pcs;
    b[111]     = rdst;
    b[110:79]  = 32'hDEAD_BEEF;
    b[78:47]   = 32'h1234_5678;
    b[46:15]   = 32'h0000_00A5;
    b[14:10]   = rt;
    b[9:5]     = rd;
    b[4:0]     = 5'd17;
    return b;
  endfunction

  // Drive one cycle of IF/ID + ID/EX state, then check dut_a at negedge.
  task automatic apply(input string tag, input logic [121:0] bus,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic exp_go);
    @(posedge clk);
    #1;
    idex_bus     = bus;
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_uses_rt = uses;
    @(negedge clk);
    check({tag, "_pc_write"}, 32'(a_pc_write), 32'(exp_go));
    check({tag, "_idex_nop"}, 32'(a_idex_nop), 32'(exp_go));
  endtask

  initial begin
    rst          = 1'b1;
    idex_bus     = '0;
    ifid_rs      = 5'd0;
    ifid_rt      = 5'd0;
    ifid_uses_rt = 1'b0;

    // Reset: outputs gated low, counters clear.
    @(negedge clk);
    check("rst_pc_write",   32'(a_pc_write),   32'd0);
    check("rst_ifid_write", 32'(a_ifid_write), 32'd0);
    check("rst_idex_nop",   32'(a_idex_nop),   32'd0);
    check("rst_ifid_flush", 32'(a_ifid_flush), 32'd0);
    check("rst_stall_cnt",  32'(a_stall_cnt),  32'd0);
    check("rst_flush_cnt",  32'(a_flush_cnt),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load-use (lw rt=5 ; use rs=5): 1 stall cycle on A, 3 on B.
    idex_bus     = mk_bus(1'b1, 2'b00, 1'b0, 5'd5, 5'd0);
    ifid_rs      = 5'd5;
    ifid_rt      = 5'd0;
    ifid_uses_rt = 1'b1;
    @(negedge clk);
    check("lu_a_pc_write",   32'(a_pc_write),   32'd0);
    check("lu_a_ifid_write", 32'(a_ifid_write), 32'd0);
    check("lu_a_idex_nop",   32'(a_idex_nop),   32'd0);
    check("lu_a_ifid_flush", 32'(a_ifid_flush), 32'd0);
    check("lu_b_pc_write",   32'(b_pc_write),   32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 idex_bus = '0;  // bubble now in ID/EX
      @(negedge clk);
      check($sformatf("lu_a_pc_write_c%0d", i), 32'(a_pc_write), 32'd1);
      check($sformatf("lu_a_idex_nop_c%0d", i), 32'(a_idex_nop), 32'd1);
      check($sformatf("lu_b_pc_write_c%0d", i), 32'(b_pc_write), (i < 3) ? 32'd0 : 32'd1);
      check($sformatf("lu_b_idex_nop_c%0d", i), 32'(b_idex_nop), (i < 3) ? 32'd0 : 32'd1);
    end
    check("lu_a_stall_cnt", 32'(a_stall_cnt), 32'd1);
    check("lu_b_stall_cnt", 32'(b_stall_cnt), 32'd3);

    // Control transfer together with a matching load-use: flush wins.
    @(posedge clk);
    #1 idex_bus = mk_bus(1'b1, 2'b01, 1'b0, 5'd5, 5'd0);
    @(negedge clk);
    check("fl_a_ifid_flush", 32'(a_ifid_flush), 32'd1);
    check("fl_a_idex_nop",   32'(a_idex_nop),   32'd0);
    check("fl_a_pc_write",   32'(a_pc_write),   32'd1);
    check("fl_a_ifid_write", 32'(a_ifid_write), 32'd1);
    check("fl_b_pc_write",   32'(b_pc_write),   32'd1);
    @(posedge clk);
    #1 idex_bus = '0;
    @(negedge clk);
    check("fl_a_ifid_flush_after", 32'(a_ifid_flush), 32'd0);
    check("fl_a_flush_cnt",        32'(a_flush_cnt),  32'd1);
    check("fl_a_stall_cnt",        32'(a_stall_cnt),  32'd1);
    check("fl_b_stall_cnt",        32'(b_stall_cnt),  32'd3);

    // No-stall cases.
    apply("ns_dest0",   mk_bus(1'b1, 2'b00, 1'b0, 5'd0, 5'd0), 5'd0, 5'd0, 1'b1, 1'b1);
    check("ns_dest0_b_pc_write", 32'(b_pc_write), 32'd1);
    apply("ns_rt_unused", mk_bus(1'b1, 2'b00, 1'b0, 5'd7, 5'd0), 5'd3, 5'd7, 1'b0, 1'b1);
    check("ns_rt_unused_b_pc_write", 32'(b_pc_write), 32'd1);
    apply("ns_no_memrd", mk_bus(1'b0, 2'b00, 1'b1, 5'd2, 5'd9), 5'd9, 5'd0, 1'b0, 1'b1);
    apply("ns_regdst_rt", mk_bus(1'b1, 2'b00, 1'b1, 5'd9, 5'd4), 5'd9, 5'd0, 1'b0, 1'b1);

    // Positive controls: rt match when rt is read, and rd dest with RegDst=1.
    apply("st_rt_used", mk_bus(1'b1, 2'b00, 1'b0, 5'd7, 5'd0), 5'd3, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply($sformatf("drain1_%0d", i), '0, 5'd0, 5'd0, 1'b0, 1'b1);
    apply("st_regdst_rd", mk_bus(1'b1, 2'b00, 1'b1, 5'd2, 5'd9), 5'd9, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply($sformatf("drain2_%0d", i), '0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("mix_a_stall_cnt", 32'(a_stall_cnt), 32'd3);
    check("mix_b_stall_cnt", 32'(b_stall_cnt), 32'd9);

    // Reset during the second cycle of B's 3-cycle stall.
    apply("rs_hazard", mk_bus(1'b1, 2'b00, 1'b0, 5'd5, 5'd0), 5'd5, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 idex_bus = '0;
    @(negedge clk);
    check("rs_b_pc_write_pre", 32'(b_pc_write), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rs_b_pc_write",   32'(b_pc_write),   32'd0);
    check("rs_b_ifid_write", 32'(b_ifid_write), 32'd0);
    check("rs_b_idex_nop",   32'(b_idex_nop),   32'd0);
    check("rs_b_ifid_flush", 32'(b_ifid_flush), 32'd0);
    check("rs_b_stall_cnt",  32'(b_stall_cnt),  32'd0);
    check("rs_a_flush_cnt",  32'(a_flush_cnt),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rs_b_pc_write_rel", 32'(b_pc_write), 32'd1);
    check("rs_b_idex_nop_rel", 32'(b_idex_nop), 32'd1);
    check("rs_b_stall_cnt_rel", 32'(b_stall_cnt), 32'd0);

    // 20 consecutive hazard cycles: 4-bit counter saturates, 16-bit does not.
    @(posedge clk);
    #1;
    idex_bus = mk_bus(1'b1, 2'b00, 1'b0, 5'd5, 5'd0);
    ifid_rs  = 5'd5;
    repeat (20) @(posedge clk);
    #1;
    check("sat_c_pc_write",  32'(c_pc_write),  32'd0);
    check("sat_c_stall_cnt", 32'(c_stall_cnt), 32'hF);
    check("sat_a_stall_cnt", 32'(a_stall_cnt), 32'd20);
    check("sat_b_stall_cnt", 32'(b_stall_cnt), 32'd20);
    idex_bus = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
